// File: rtl/usb_rx_field_ctrl.sv
// USB receive field sequencer: routes decoded bits to the PID/payload shift registers,
// counts bits and bytes, checks the PID. Optional PID type decode: PID_TYPE_DECODE_EN.
module usb_rx_field_ctrl #(
    parameter int unsigned MAX_BYTES = 64,
    parameter int unsigned CNT_W     = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sync_det,
    input  logic             data_shift,
    input  logic             stuff_skip,
    input  logic             eop,
    input  logic [7:0]       pid_data,
    output logic             SR_select,
    output logic             read_val,
    output logic             byte_done,
    output logic [CNT_W-1:0] byte_cnt,
    output logic             pid_valid,
    output logic             pid_err,
    output logic             pkt_done,
    output logic             pkt_err,
`ifdef PID_TYPE_DECODE_EN
    output logic [1:0]       pid_type,
`endif
    output logic             busy
);

    typedef enum logic [2:0] {StIdle, StPid, StPidChk, StPayload, StErr} state_e;

    state_e           state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic             pid_valid_q, pid_valid_d;
    logic             sr_select_q;
    logic             byte_done_q, byte_done_d;
    logic             pkt_done_q, pkt_done_d;
    logic             pkt_err_q, pkt_err_d;
    logic             accept, pid_ok, is_handshake;

`ifdef PID_TYPE_DECODE_EN
    logic [1:0] pid_type_q, pid_type_d;
    assign is_handshake = (pid_type_q == 2'b10);
    assign pid_type     = pid_type_q;
`else
    assign is_handshake = 1'b0;
`endif

    assign accept = data_shift & ~stuff_skip;
    assign pid_ok = (pid_data[7:4] == ~pid_data[3:0]);

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        pid_valid_d = pid_valid_q;
        byte_done_d = 1'b0;
        pkt_done_d  = 1'b0;
        pkt_err_d   = 1'b0;
        pid_err     = 1'b0;
`ifdef PID_TYPE_DECODE_EN
        pid_type_d  = pid_type_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (sync_det) begin
                    state_d     = StPid;
                    bit_cnt_d   = 3'd0;
                    byte_cnt_d  = '0;
                    pid_valid_d = 1'b0;
                end
            end
            StPid: begin
                // eop wins over a coincident bit, which is dropped
                if (eop) begin
                    pkt_err_d = 1'b1;
                    state_d   = StIdle;
                end else if (accept) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = StPidChk;
                end
            end
            StPidChk: begin
                if (pid_ok) begin
                    pid_valid_d = 1'b1;
                    state_d     = StPayload;
`ifdef PID_TYPE_DECODE_EN
                    pid_type_d  = pid_data[1:0];
`endif
                end else begin
                    pid_err = 1'b1;
                    state_d = StErr;
                end
            end
            StPayload: begin
                if (eop) begin
                    if (bit_cnt_q == 3'd0) pkt_done_d = 1'b1;
                    else                   pkt_err_d  = 1'b1;
                    state_d = StIdle;
                end else if (accept) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (is_handshake || (byte_cnt_q == CNT_W'(MAX_BYTES))) begin
                            pkt_err_d = 1'b1;
                            state_d   = StErr;
                        end else begin
                            byte_done_d = 1'b1;
                            byte_cnt_d  = byte_cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            StErr: begin
                if (eop) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            bit_cnt_q   <= 3'd0;
            byte_cnt_q  <= '0;
            pid_valid_q <= 1'b0;
            sr_select_q <= 1'b0;
            byte_done_q <= 1'b0;
            pkt_done_q  <= 1'b0;
            pkt_err_q   <= 1'b0;
`ifdef PID_TYPE_DECODE_EN
            pid_type_q  <= 2'b00;
`endif
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            pid_valid_q <= pid_valid_d;
            sr_select_q <= (state_d == StPayload);
            byte_done_q <= byte_done_d;
            pkt_done_q  <= pkt_done_d;
            pkt_err_q   <= pkt_err_d;
`ifdef PID_TYPE_DECODE_EN
            pid_type_q  <= pid_type_d;
`endif
        end
    end

    assign read_val  = ((state_q == StPid) || (state_q == StPayload)) && !stuff_skip;
    assign SR_select = sr_select_q;
    assign byte_done = byte_done_q;
    assign byte_cnt  = byte_cnt_q;
    assign pid_valid = pid_valid_q;
    assign pkt_done  = pkt_done_q;
    assign pkt_err   = pkt_err_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_usb_rx_field_ctrl.sv
// Directed bench for usb_rx_field_ctrl (MAX_BYTES = 4); pulses are tallied on negedge.
module tb_usb_rx_field_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sync_det = 1'b0, data_shift = 1'b0, stuff_skip = 1'b0, eop = 1'b0;
    logic [7:0] pid_data = 8'h00;
    logic       SR_select, read_val, byte_done, pid_valid, pid_err, pkt_done, pkt_err, busy;
    logic [6:0] byte_cnt;
`ifdef PID_TYPE_DECODE_EN
    logic [1:0] pid_type;
`endif

    int n_cmp = 0, n_bad = 0;
    int n_bd = 0, n_pd = 0, n_pe = 0, n_pide = 0;
    int b_bd, b_pd, b_pe, b_pide;

    usb_rx_field_ctrl #(.MAX_BYTES(4), .CNT_W(7)) dut (
        .clk(clk), .rst(rst), .sync_det(sync_det), .data_shift(data_shift),
        .stuff_skip(stuff_skip), .eop(eop), .pid_data(pid_data),
        .SR_select(SR_select), .read_val(read_val), .byte_done(byte_done),
        .byte_cnt(byte_cnt), .pid_valid(pid_valid), .pid_err(pid_err),
        .pkt_done(pkt_done), .pkt_err(pkt_err),
`ifdef PID_TYPE_DECODE_EN
        .pid_type(pid_type),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (byte_done) n_bd++;
        if (pkt_done)  n_pd++;
        if (pkt_err)   n_pe++;
        if (pid_err)   n_pide++;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mark();
        b_bd = n_bd; b_pd = n_pd; b_pe = n_pe; b_pide = n_pide;
    endtask

    task automatic send_bit(input logic skip);
        data_shift = 1'b1;
        stuff_skip = skip;
        tick();
        data_shift = 1'b0;
        stuff_skip = 1'b0;
        tick();
    endtask

    task automatic send_bits(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b0);
    endtask

    task automatic pulse_sync();
        sync_det = 1'b1;
        tick();
        sync_det = 1'b0;
    endtask

    task automatic pulse_eop();
        eop = 1'b1;
        tick();
        eop = 1'b0;
        tick();
    endtask

    initial begin
        // Reset state
        tick(); tick();
        check_eq("rst_sr_select", SR_select, 0);
        check_eq("rst_read_val", read_val, 0);
        check_eq("rst_byte_cnt", byte_cnt, 0);
        check_eq("rst_pid_valid", pid_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_pulses", byte_done + pkt_done + pkt_err + pid_err, 0);
        rst = 1'b0;
        tick();

        // DATA0 packet, 3 payload bytes
        mark();
        pid_data = 8'hC3;
        pulse_sync();
        check_eq("d0_busy", busy, 1);
        check_eq("d0_read_val_pid", read_val, 1);
        check_eq("d0_sr_select_pid", SR_select, 0);
        send_bits(8);
        check_eq("d0_pid_valid", pid_valid, 1);
        check_eq("d0_sr_select_payload", SR_select, 1);
        send_bits(24);
        check_eq("d0_byte_done", n_bd - b_bd, 3);
        check_eq("d0_byte_cnt", byte_cnt, 3);
        pulse_eop();
        check_eq("d0_pkt_done", n_pd - b_pd, 1);
        check_eq("d0_pkt_err", n_pe - b_pe, 0);
        check_eq("d0_sr_select_idle", SR_select, 0);
        check_eq("d0_busy_idle", busy, 0);
        check_eq("d0_byte_cnt_hold", byte_cnt, 3);
        check_eq("d0_pid_valid_hold", pid_valid, 1);
        data_shift = 1'b1;
        #1 check_eq("idle_read_val", read_val, 0);
        tick();
        data_shift = 1'b0;
        tick();

        // Bad PID
        mark();
        pid_data = 8'hC4;
        pulse_sync();
        check_eq("bad_pid_valid_cleared", pid_valid, 0);
        send_bits(8);
        check_eq("bad_pid_err", n_pide - b_pide, 1);
        check_eq("bad_read_val", read_val, 0);
        check_eq("bad_busy", busy, 1);
        send_bits(8);
        check_eq("bad_byte_done", n_bd - b_bd, 0);
        pulse_eop();
        check_eq("bad_busy_idle", busy, 0);
        check_eq("bad_no_pulses", (n_pd - b_pd) + (n_pe - b_pe), 0);

        // Stuffed bits in byte 1, then truncated byte 2
        mark();
        pid_data = 8'hC3;
        pulse_sync();
        send_bits(8);
        send_bits(3);
        data_shift = 1'b1;
        stuff_skip = 1'b1;
        #1 check_eq("stuff_read_val_1", read_val, 0);
        tick();
        data_shift = 1'b0;
        stuff_skip = 1'b0;
        tick();
        send_bits(2);
        data_shift = 1'b1;
        stuff_skip = 1'b1;
        #1 check_eq("stuff_read_val_2", read_val, 0);
        tick();
        data_shift = 1'b0;
        stuff_skip = 1'b0;
        tick();
        send_bits(2);
        check_eq("stuff_seven_accepted", n_bd - b_bd, 0);
        send_bits(1);
        check_eq("stuff_byte_done", n_bd - b_bd, 1);
        check_eq("stuff_byte_cnt", byte_cnt, 1);
        send_bits(5);
        pulse_eop();
        check_eq("trunc_pkt_err", n_pe - b_pe, 1);
        check_eq("trunc_pkt_done", n_pd - b_pd, 0);
        check_eq("trunc_byte_cnt", byte_cnt, 1);
        check_eq("trunc_busy", busy, 0);

        // eop coincident with the 8th bit: bit dropped, so not a byte boundary
        mark();
        pulse_sync();
        send_bits(8);
        send_bits(7);
        data_shift = 1'b1;
        pulse_eop();
        data_shift = 1'b0;
        check_eq("coinc_byte_done", n_bd - b_bd, 0);
        check_eq("coinc_pkt_err", n_pe - b_pe, 1);
        check_eq("coinc_pkt_done", n_pd - b_pd, 0);
        check_eq("coinc_byte_cnt", byte_cnt, 0);

        // eop during PID
        mark();
        pulse_sync();
        send_bits(3);
        pulse_eop();
        check_eq("pid_eop_pkt_err", n_pe - b_pe, 1);
        check_eq("pid_eop_busy", busy, 0);

        // Overflow with MAX_BYTES = 4
        mark();
        pulse_sync();
        send_bits(8);
        send_bits(40);
        check_eq("ovf_byte_done", n_bd - b_bd, 4);
        check_eq("ovf_byte_cnt", byte_cnt, 4);
        check_eq("ovf_pkt_err", n_pe - b_pe, 1);
        check_eq("ovf_busy_err", busy, 1);
        check_eq("ovf_read_val", read_val, 0);
        send_bits(8);
        check_eq("ovf_byte_cnt_hold", byte_cnt, 4);
        pulse_eop();
        check_eq("ovf_busy_idle", busy, 0);
        check_eq("ovf_no_more_pulses", (n_pe - b_pe) + (n_pd - b_pd), 1);

        // Asynchronous reset mid-payload
        pulse_sync();
        send_bits(8);
        send_bits(12);
        check_eq("mid_byte_cnt_pre", byte_cnt, 1);
        #2 rst = 1'b1;
        #1;
        check_eq("mid_rst_sr_select", SR_select, 0);
        check_eq("mid_rst_byte_cnt", byte_cnt, 0);
        check_eq("mid_rst_pid_valid", pid_valid, 0);
        check_eq("mid_rst_busy", busy, 0);
        data_shift = 1'b1;
        #1 check_eq("mid_rst_read_val", read_val, 0);
        tick();
        data_shift = 1'b0;
        rst = 1'b0;
        tick();

`ifdef PID_TYPE_DECODE_EN
        // ACK handshake: pid only, then ACK plus a byte
        mark();
        pid_data = 8'hD2;
        pulse_sync();
        send_bits(8);
        check_eq("ack_pid_type", pid_type, 2);
        pulse_eop();
        check_eq("ack_pkt_done", n_pd - b_pd, 1);
        mark();
        pulse_sync();
        send_bits(16);
        check_eq("ack_byte_pkt_err", n_pe - b_pe, 1);
        check_eq("ack_byte_done", n_bd - b_bd, 0);
        pulse_eop();
        check_eq("ack_byte_pkt_done", n_pd - b_pd, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/usb_rx_field_ctrl.md
Name: usb_rx_field_ctrl

Overview:
- Sequences the USB receive field shift registers for one packet at a time.
- Sits between the bit decoder/unstuffer and the PID and payload shift registers.
- Drives the SR_select/read_val qualifiers, counts bits and bytes, and checks the PID against its complement.
- Reports packet completion and errors to the protocol FSM.

Parameters:
MAX_BYTES, 64, maximum payload bytes accepted after the PID (CRC bytes included)
CNT_W, 7, width of byte_cnt; must hold MAX_BYTES

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
sync_det  in  1  one-cycle pulse: SYNC pattern detected, packet starts
data_shift  in  1  one decoded bit valid this cycle; never asserted in two consecutive cycles
stuff_skip  in  1  qualifies data_shift: this bit is a stuffed bit and is discarded
eop  in  1  one-cycle pulse: end of packet detected
pid_data  in  8  parallel PID shift register value
SR_select  out  1  0 = bits routed to PID SR, 1 = bits routed to payload SR
read_val  out  1  bit-acceptance qualifier to both shift registers
byte_done  out  1  one-cycle pulse: a payload byte is complete in the payload SR
byte_cnt  out  CNT_W  payload bytes completed in the current packet
pid_valid  out  1  level: PID captured and check passed
pid_err  out  1  one-cycle pulse: PID check failed
pkt_done  out  1  one-cycle pulse: packet ended cleanly on a byte boundary
pkt_err  out  1  one-cycle pulse: framing, overflow or truncation error
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: state = IDLE, bit_cnt = 0, byte_cnt = 0.
- Reset output values: SR_select = 0, read_val = 0, all pulses 0, pid_valid = 0.
- Accepted bit: data_shift & ~stuff_skip. The 3-bit bit_cnt counts accepted bits modulo 8.
- read_val is combinational: high in PID or PAYLOAD state when stuff_skip = 0, else 0.
- SR_select is registered: 1 in PAYLOAD, 0 in all other states.
- eop has priority over data_shift in the same cycle; the coincident bit is discarded.
- sync_det is ignored outside IDLE.
- IDLE:
  - On sync_det: go to PID, clear bit_cnt, byte_cnt and pid_valid.
- PID:
  - On the 8th accepted bit: go to PID_CHK.
  - On eop: pkt_err pulse, go to IDLE.
- PID_CHK (one cycle, read_val = 0):
  - If pid_data[7:4] == ~pid_data[3:0]: set pid_valid, go to PAYLOAD.
  - Else: pid_err pulse, go to ERR.
- PAYLOAD:
  - On the 8th accepted bit: byte_done pulses the following cycle and byte_cnt increments in that same cycle.
  - If a byte completes while byte_cnt == MAX_BYTES: pkt_err pulse, go to ERR. byte_cnt holds and byte_done is not pulsed.
  - On eop with bit_cnt == 0: pkt_done pulse the next cycle, go to IDLE.
  - On eop with bit_cnt != 0: pkt_err pulse, go to IDLE.
- ERR (read_val = 0):
  - Wait for eop, then go to IDLE with no further pulses.
- Output retention in IDLE: pid_valid and byte_cnt hold their last values until the next sync_det.
- Reset mid-packet: immediate return to IDLE with reset values.

Optional Feature:
- Macro: PID_TYPE_DECODE_EN.
- Defined:
  - Adds output pid_type[1:0] = pid_data[1:0], registered in PID_CHK on pass; reset value 2'b00.
  - If pid_type == 2'b10 (handshake), any completed payload byte causes a pkt_err pulse and a move to ERR.
  - eop immediately after PID_CHK with pid_type == 2'b10 gives pkt_done.
- Not defined: port absent, no type-dependent checks; handshake packets are treated like any other.

Test Plan:
- Reset then idle: assert rst mid-PAYLOAD -> outputs at reset values same cycle; busy = 0; read_val = 0 with data_shift pulsing.
- DATA0 packet: sync_det, PID bits giving pid_data = 0xC3, 3 payload bytes, eop on a byte boundary -> pid_valid = 1, byte_done x3, byte_cnt = 3, pkt_done once, SR_select = 1 only during payload.
- Bad PID: pid_data = 0xC4 -> pid_err pulse in PID_CHK cycle; read_val = 0 thereafter; eop -> IDLE with no pkt_done/pkt_err.
- Stuffed bits: 2 stuffed bits (stuff_skip = 1) inside byte 1 -> read_val low on those cycles; byte_done still after exactly 8 accepted bits; byte_cnt = 1.
- Truncated packet: eop after 5 bits of byte 2 -> pkt_err pulse, byte_cnt = 1, state IDLE. Also: eop coincident with a data_shift -> bit discarded.
- Overflow: MAX_BYTES = 4, send 5 bytes -> byte_cnt saturates at 4, pkt_err on 5th byte, ERR until eop. With PID_TYPE_DECODE_EN: ACK pid_data = 0xD2 then eop -> pid_type = 2'b10, pkt_done; ACK plus 1 byte -> pkt_err.
